// File: rtl/sd_seq_pkg.sv
// sd_seq_pkg: shared types and constants for the SD command sequencer.
//   sd_state_e  - sequencer states
//   wr_phase_e  - register-writer handshake phases
//   reg_wr_t    - one controller register write (address + data)
//   ARG0..ARG3, FLAGS, CMDIDX, BLKCFG, STATUS - controller register addresses
//   CMD0, CMD7, CMD17, CMD17_FLAGS            - command index / flag values
//   seq_len()   - number of register writes issued by a command state
//   seq_write() - the write issued at a given step of a command state
package sd_seq_pkg;

   typedef enum logic [2:0] {
      StInitCmd0,
      StWait0,
      StInitCmd7,
      StPoll7,
      StIdle,
      StRdCmd17,
      StPoll17,
      StFail
   } sd_state_e;

   typedef enum logic [1:0] {
      PhIdle,
      PhSetup,
      PhStrobe
   } wr_phase_e;

   typedef struct packed {
      logic [6:0] addr;
      logic [7:0] data;
   } reg_wr_t;

   localparam logic [6:0] ARG0   = 7'h00;
   localparam logic [6:0] ARG1   = 7'h01;
   localparam logic [6:0] ARG2   = 7'h02;
   localparam logic [6:0] ARG3   = 7'h03;
   localparam logic [6:0] FLAGS  = 7'h04;
   localparam logic [6:0] CMDIDX = 7'h05;
   localparam logic [6:0] BLKCFG = 7'h48;
   localparam logic [6:0] STATUS = 7'h0C;

   localparam logic [7:0] CMD0        = 8'd0;
   localparam logic [7:0] CMD7        = 8'd7;
   localparam logic [7:0] CMD17       = 8'd17;
   localparam logic [7:0] CMD17_FLAGS = 8'b0111_1101;

   function automatic logic [2:0] seq_len(input sd_state_e st);
      case (st)
         StInitCmd0: return 3'd2;
         StInitCmd7: return 3'd6;
         StRdCmd17:  return 3'd7;
         default:    return 3'd0;
      endcase
   endfunction

   // The write to ARG0 always comes last because it launches the command.
   function automatic reg_wr_t seq_write(input sd_state_e   st,
                                         input logic [2:0]  step,
                                         input logic [15:0] rca,
                                         input logic [31:0] blk);
      reg_wr_t w;
      w = '0;
      case (st)
         StInitCmd0: begin
            case (step)
               3'd0:    w = '{CMDIDX, CMD0};
               default: w = '{ARG0, 8'h00};
            endcase
         end
         StInitCmd7: begin
            case (step)
               3'd0:    w = '{CMDIDX, CMD7};
               3'd1:    w = '{FLAGS, 8'h00};
               3'd2:    w = '{ARG3, rca[15:8]};
               3'd3:    w = '{ARG2, rca[7:0]};
               3'd4:    w = '{ARG1, 8'h00};
               default: w = '{ARG0, 8'h00};
            endcase
         end
         StRdCmd17: begin
            case (step)
               3'd0:    w = '{BLKCFG, 8'h00};
               3'd1:    w = '{CMDIDX, CMD17};
               3'd2:    w = '{FLAGS, CMD17_FLAGS};
               3'd3:    w = '{ARG3, blk[31:24]};
               3'd4:    w = '{ARG2, blk[23:16]};
               3'd5:    w = '{ARG1, blk[15:8]};
               default: w = '{ARG0, blk[7:0]};
            endcase
         end
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/sd_reg_writer.sv
// sd_reg_writer: two-cycle controller register write.
// A start loads wr_addr/wr_data; the next cycle is SETUP (addr/data_out driven, we=0), the
// one after is STROBE (we=1). addr/data_out hold their value until the next start.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   start             - load a new write (accepted when idle or in the STROBE cycle)
//   wr_addr, wr_data  - register address / data for the write being started
//   busy              - a write is in its SETUP or STROBE cycle
//   last              - STROBE cycle: the current write completes this cycle
//   addr, data_out    - registered bus outputs
//   we                - write strobe
module sd_reg_writer
   import sd_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       busy,
   output logic       last,
   output logic [6:0] addr,
   output logic [7:0] data_out,
   output logic       we
);

   wr_phase_e  ph_q, ph_d;
   logic [6:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic       load;

   always_comb begin
      ph_d   = ph_q;
      addr_d = addr_q;
      data_d = data_q;
      // Loading during STROBE lets writes run back to back with no gap.
      load   = start && (ph_q != PhSetup);
      case (ph_q)
         PhSetup:  ph_d = PhStrobe;
         PhStrobe: ph_d = PhIdle;
         default:  ph_d = PhIdle;
      endcase
      if (load) begin
         ph_d   = PhSetup;
         addr_d = wr_addr;
         data_d = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph_q   <= PhIdle;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         ph_q   <= ph_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign busy     = (ph_q != PhIdle);
   assign last     = (ph_q == PhStrobe);
   assign we       = (ph_q == PhStrobe);
   assign addr     = addr_q;
   assign data_out = data_q;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: drives an SD host controller's register file to initialise a card
// (CMD0, wait, CMD7 select) and then issue single-block reads (CMD17) on request.
// Optional build macro: SD_SEQ_TIMEOUT_EN - when defined, a status poll lasting
// TIMEOUT_CYCLES cycles enters FAIL; otherwise polling waits indefinitely.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   req_valid  - block-read request;  req_ready - sequencer idle, request accepted
//   req_block  - SD block address (captured on acceptance)
//   addr       - controller register address; data_out / we - write data and strobe
//   data_in    - controller read data, valid one cycle after addr
//   done       - one-cycle pulse when a read command completes
//   error      - sticky failure flag (command error or poll timeout), cleared by reset
module sd_cmd_sequencer
   import sd_seq_pkg::*;
#(
   parameter logic [15:0] RCA            = 16'h0013,
   parameter int unsigned CMD0_WAIT      = 250,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_block,
   output logic [6:0]  addr,
   output logic [7:0]  data_out,
   output logic        we,
   input  logic [7:0]  data_in,
   output logic        done,
   output logic        error
);

   localparam logic [31:0] WaitLast = (CMD0_WAIT > 0) ? 32'(CMD0_WAIT - 1) : 32'd0;

   sd_state_e   st_q, st_d;
   logic [2:0]  step_q, step_d;
   logic [31:0] wait_q, wait_d;
   logic [31:0] blk_q, blk_d;
   logic        poll_ph_q, poll_ph_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   reg_wr_t     wr_req;
   logic        wr_start;
   logic        wr_busy;
   logic        wr_last;
   logic [6:0]  wr_addr_out;
   logic        in_poll;

`ifdef SD_SEQ_TIMEOUT_EN
   localparam logic [31:0] TmoLast = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
   logic [31:0] tmo_q, tmo_d;
`else
   logic [31:0] unused_tmo;
   assign unused_tmo = TIMEOUT_CYCLES;
`endif

   logic unused_status;
   assign unused_status = ^data_in[7:2];

   assign in_poll = (st_q == StPoll7) || (st_q == StPoll17);

   always_comb begin
      st_d      = st_q;
      step_d    = step_q;
      wait_d    = '0;
      blk_d     = blk_q;
      poll_ph_d = 1'b0;
      done_d    = 1'b0;
      wr_start  = 1'b0;
      wr_req    = seq_write(st_q, step_q, RCA, blk_q);
`ifdef SD_SEQ_TIMEOUT_EN
      tmo_d     = '0;
`endif
      case (st_q)
         StInitCmd0, StInitCmd7, StRdCmd17: begin
            if (!wr_busy || wr_last) begin
               if (step_q < seq_len(st_q)) begin
                  wr_start = 1'b1;
                  step_d   = step_q + 3'd1;
               end else begin
                  // Final strobe of the command is happening this cycle.
                  step_d = '0;
                  st_d   = (st_q == StInitCmd0) ? StWait0 :
                           (st_q == StInitCmd7) ? StPoll7 : StPoll17;
               end
            end
         end
         StWait0: begin
            wait_d = wait_q + 32'd1;
            if (wait_q == WaitLast) begin
               wait_d = '0;
               st_d   = StInitCmd7;
            end
         end
         StPoll7, StPoll17: begin
            // addr is held at STATUS; data_in is only trusted on the second cycle.
            poll_ph_d = ~poll_ph_q;
            if (poll_ph_q) begin
               if (data_in[1]) begin
                  st_d = StFail;
               end else if (data_in[0]) begin
                  st_d   = StIdle;
                  done_d = (st_q == StPoll17);
               end
            end
`ifdef SD_SEQ_TIMEOUT_EN
            tmo_d = tmo_q + 32'd1;
            if ((st_d == st_q) && (tmo_q == TmoLast)) begin
               st_d = StFail;
            end
`endif
         end
         StIdle: begin
            if (req_valid) begin
               // First write issued on acceptance so the first strobe lands 2 cycles later.
               blk_d    = req_block;
               wr_req   = seq_write(StRdCmd17, 3'd0, RCA, req_block);
               wr_start = 1'b1;
               step_d   = 3'd1;
               st_d     = StRdCmd17;
            end
         end
         default: st_d = st_q;
      endcase
      err_d = err_q | (st_d == StFail);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q      <= StInitCmd0;
         step_q    <= '0;
         wait_q    <= '0;
         blk_q     <= '0;
         poll_ph_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         st_q      <= st_d;
         step_q    <= step_d;
         wait_q    <= wait_d;
         blk_q     <= blk_d;
         poll_ph_q <= poll_ph_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

`ifdef SD_SEQ_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   sd_reg_writer u_writer (
      .clk      (clk),
      .rst      (rst),
      .start    (wr_start),
      .wr_addr  (wr_req.addr),
      .wr_data  (wr_req.data),
      .busy     (wr_busy),
      .last     (wr_last),
      .addr     (wr_addr_out),
      .data_out (data_out),
      .we       (we)
   );

   assign addr      = in_poll ? STATUS : wr_addr_out;
   assign req_ready = (st_q == StIdle);
   assign done      = done_q;
   assign error     = err_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_sd_cmd_sequencer;

   localparam int unsigned CMD0_WAIT      = 20;
   localparam int unsigned TIMEOUT_CYCLES = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_block = '0;
   logic [6:0]  addr;
   logic [7:0]  data_out;
   logic        we;
   logic [7:0]  data_in = 8'h00;
   logic        done;
   logic        error;

   logic [7:0]  status_val = 8'h00;
   int          errors = 0;
   int          checks = 0;
   logic [14:0] exp_q[$];
   int          strobe_cyc[$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          lat_ref = -1;
   logic [6:0]  prev_addr = '0;
   logic [7:0]  prev_data = '0;

   sd_cmd_sequencer #(
      .RCA            (16'h0013),
      .CMD0_WAIT      (CMD0_WAIT),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_block (req_block),
      .addr      (addr),
      .data_out  (data_out),
      .we        (we),
      .data_in   (data_in),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   // Controller register-file model: status readable one cycle after addr.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      data_in <= (addr == 7'h0C) ? status_val : 8'h00;
   end

   // Scoreboard monitor: every strobe pops one expected write.
   always @(negedge clk) begin
      logic [14:0] e;
      if (done) done_cnt++;
      if (we) begin
         strobe_cyc.push_back(cyc);
         if (lat_ref >= 0) begin
            checks++;
            if (cyc - lat_ref != 2) begin
               errors++;
               $display("FAIL req_to_we_latency: got %0d cycles, expected 2", cyc - lat_ref);
            end
            lat_ref = -1;
         end
         checks++;
         if (prev_addr !== addr || prev_data !== data_out) begin
            errors++;
            $display("FAIL setup_stable: setup addr=%h data=%h, strobe addr=%h data=%h",
                     prev_addr, prev_data, addr, data_out);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_we: got addr=%h data=%h, expected no write", addr, data_out);
         end else begin
            e = exp_q.pop_front();
            if ({addr, data_out} !== e) begin
               errors++;
               $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                        addr, data_out, e[14:8], e[7:0]);
            end
         end
      end
      prev_addr = addr;
      prev_data = data_out;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [6:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic push_init();
      push(7'd5, 8'h00); push(7'd0, 8'h00);
      push(7'd5, 8'h07); push(7'd4, 8'h00); push(7'd3, 8'h00);
      push(7'd2, 8'h13); push(7'd1, 8'h00); push(7'd0, 8'h00);
   endtask

   task automatic push_rd(input logic [31:0] b);
      push(7'h48, 8'h00); push(7'd5, 8'd17); push(7'd4, 8'h7D);
      push(7'd3, b[31:24]); push(7'd2, b[23:16]); push(7'd1, b[15:8]); push(7'd0, b[7:0]);
   endtask

   task automatic drain(input string name, input int bound);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         tick();
         n++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic wait_ready(input string name, input int bound);
      int n;
      n = 0;
      while (!req_ready && n < bound) begin
         tick();
         n++;
      end
      check(name, req_ready, 1'b1);
   endtask

   // Issue a read for b, then change req_block to b_after right after acceptance.
   task automatic issue_read(input logic [31:0] b, input logic [31:0] b_after);
      status_val = 8'h00;
      push_rd(b);
      req_valid  = 1'b1;
      req_block  = b;
      lat_ref    = cyc;
      tick();
      req_valid  = 1'b0;
      req_block  = b_after;
      drain("rd_writes", 40);
   endtask

   task automatic read_ok(input logic [31:0] b, input logic [31:0] b_after);
      int d0;
      d0 = done_cnt;
      issue_read(b, b_after);
      status_val = 8'h01;
      wait_ready("rd_ready_back", 6);
      repeat (3) tick();
      check("done_once", done_cnt - d0, 1);
      check("rd_no_error", error, 1'b0);
   endtask

   initial begin
      int d0;
      repeat (3) tick();
      check("rst_we", we, 1'b0);
      check("rst_addr", addr, 7'h00);
      check("rst_data", data_out, 8'h00);
      check("rst_ready", req_ready, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);

      // Init sequence
      status_val = 8'h01;
      push_init();
      strobe_cyc.delete();
      rst = 1'b0;
      drain("init_writes", 300);
      check("cmd0_wait_gap", (strobe_cyc[2] - strobe_cyc[1]) >= int'(CMD0_WAIT + 2), 1'b1);
      wait_ready("init_ready_3cyc", 3);

      // Reads with stale req_block after acceptance
      read_ok(32'h0000_1234, 32'hDEAD_BEEF);
      read_ok(32'hA5C3_0F81, 32'h1111_1111);

      // Reset during the third RD_CMD17 write
      status_val = 8'h00;
      push(7'h48, 8'h00); push(7'd5, 8'd17);
      req_valid = 1'b1;
      req_block = 32'h0102_0304;
      tick();
      req_valid = 1'b0;
      drain("pre_rst_writes", 20);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("third_strobe_we", we, 1'b1);
      check("third_strobe_addr", addr, 7'h04);
      rst = 1'b1;
      #1;
      check("rst_abort_we", we, 1'b0);
      check("rst_abort_addr", addr, 7'h00);
      push_init();
      status_val = 8'h01;
      tick();
      rst = 1'b0;
      drain("restart_writes", 300);
      wait_ready("restart_ready", 4);

      // Status error during POLL17
      d0 = done_cnt;
      issue_read(32'h0000_0042, 32'h0);
      status_val = 8'h02;
      repeat (10) tick();
      check("fail_error", error, 1'b1);
      check("fail_ready", req_ready, 1'b0);
      req_valid = 1'b1;
      repeat (30) tick();
      req_valid = 1'b0;
      check("fail_sticky", error, 1'b1);
      check("fail_ready_stays", req_ready, 1'b0);
      check("fail_no_done", done_cnt - d0, 0);

      // Poll timeout behaviour
      rst = 1'b1;
      tick();
      check("rst_clears_error", error, 1'b0);
      push_init();
      status_val = 8'h01;
      rst = 1'b0;
      drain("init2_writes", 300);
      wait_ready("init2_ready", 4);
      d0 = done_cnt;
      issue_read(32'h0000_0007, 32'h0);
      status_val = 8'h00;
`ifdef SD_SEQ_TIMEOUT_EN
      repeat (90) tick();
      check("tmo_not_early", error, 1'b0);
      begin
         int n;
         n = 0;
         while (!error && n < 20) begin
            tick();
            n++;
         end
      end
      check("tmo_error", error, 1'b1);
      check("tmo_ready", req_ready, 1'b0);
`else
      repeat (1000) tick();
      check("no_tmo_error", error, 1'b0);
      check("no_tmo_ready", req_ready, 1'b0);
      check("no_tmo_done", done_cnt - d0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
